// File: rtl/flit_capture_buf.sv
// Sink-side flit capture RAM: records one burst, flags end-of-burst (full or idle timeout), registered readback.
// Optional build macro CAPTURE_DROP_ZERO_EN: all-zero flits are treated as null flits and discarded.
module flit_capture_buf #(
  parameter int DW      = 20,
  parameter int DEPTH   = 30,
  parameter int AW      = 5,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          clear,
  input  logic [DW-1:0] datain,
  input  logic          in_valid,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic [AW:0]   count,
  output logic          done,
  output logic          overflow
);

  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [IW-1:0] IDLE_LAST = (TIMEOUT > 0) ? IW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

  state_t        state, next_state;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [IW-1:0] idle_cnt;
  logic          flit;
  logic          arm;
  logic          wr_en;
  logic          idle_inc;
  logic          set_ovf;

`ifdef CAPTURE_DROP_ZERO_EN
  assign flit = in_valid && (datain != '0);
`else
  assign flit = in_valid;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  // clear overrides every other event, so it is decoded before the state case
  always_comb begin
    next_state = state;
    arm        = 1'b0;
    wr_en      = 1'b0;
    idle_inc   = 1'b0;
    set_ovf    = 1'b0;
    if (clear) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) begin
            next_state = S_CAPTURE;
            arm        = 1'b1;
          end
        end
        S_CAPTURE: begin
          if (enable) begin
            if (flit) begin
              wr_en = 1'b1;
              if (count == DEPTH_C - 1'b1) next_state = S_DONE;
            end else if (count != '0 && TIMEOUT != 0) begin
              idle_inc = 1'b1;
              if (idle_cnt == IDLE_LAST) next_state = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (flit) set_ovf = 1'b1;
        end
        default: next_state = S_IDLE;
      endcase
    end
  end

  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      count    <= '0;
      idle_cnt <= '0;
      overflow <= 1'b0;
    end else if (clear || arm) begin
      wr_ptr   <= '0;
      count    <= '0;
      idle_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr   <= wr_ptr + 1'b1;
        idle_cnt <= '0;
        if (count != DEPTH_C) count <= count + 1'b1;
      end else if (idle_inc) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
      if (set_ovf) overflow <= 1'b1;
    end
  end

  // RAM is deliberately left unreset; a same-address read sees the pre-write word
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= datain;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= ({1'b0, rd_addr} >= DEPTH_C) ? '0 : mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_flit_capture_buf.sv
// Testbench for flit_capture_buf: directed bursts plus random traffic against a burst-level reference model,
// readback checked through a scoreboard queue.
module tb_flit_capture_buf;

  localparam int DW      = 20;
  localparam int DEPTH   = 30;
  localparam int AW      = 5;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic [DW-1:0] datain = '0;
  logic          in_valid = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [AW:0]   count;
  logic          done;
  logic          overflow;

  flit_capture_buf #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .datain(datain), .in_valid(in_valid),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int sb[$];

  // Reference model: a burst is a list of accepted flits; the RAM image survives clear and reset
  int m_ram [DEPTH];
  bit m_written [DEPTH];
  bit m_armed, m_finished, m_ovf;
  int m_cnt, m_idle;

`ifdef CAPTURE_DROP_ZERO_EN
  localparam int EXP8 = 7;
`else
  localparam int EXP8 = 8;
`endif

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_flit(input bit v, input int d);
`ifdef CAPTURE_DROP_ZERO_EN
    return v && (d != 0);
`else
    return v;
`endif
  endfunction

  task automatic model_reset();
    m_armed = 0; m_finished = 0; m_ovf = 0; m_cnt = 0; m_idle = 0;
  endtask

  task automatic model_step(input bit en, input bit clr, input bit v, input int d);
    bit f;
    f = is_flit(v, d);
    if (clr) begin
      model_reset();
    end else if (m_finished) begin
      if (f) m_ovf = 1;
    end else if (!m_armed) begin
      if (en) begin m_armed = 1; m_cnt = 0; m_idle = 0; end
    end else if (en) begin
      if (f) begin
        m_ram[m_cnt] = d;
        m_written[m_cnt] = 1;
        m_cnt++;
        m_idle = 0;
        if (m_cnt == DEPTH) m_finished = 1;
      end else if (m_cnt > 0) begin
        m_idle++;
        if (TIMEOUT != 0 && m_idle == TIMEOUT) m_finished = 1;
      end
    end
  endtask

  task automatic checkOutput();
    check("count", int'(count), m_cnt);
    check("done", int'(done), int'(m_finished));
    check("overflow", int'(overflow), int'(m_ovf));
  endtask

  task automatic applyStimulus(input bit en, input bit clr, input bit v, input int d,
                               input bit rd, input int addr);
    @(negedge clk);
    enable = en; clear = clr; in_valid = v; datain = DW'(d);
    rd_en = rd; rd_addr = AW'(addr);
    if (rd) sb.push_back((addr >= DEPTH) ? 0 : m_ram[addr]);
    model_step(en, clr, v, d);
    @(posedge clk); #1;
    checkOutput();
  endtask

  task automatic pulseReset();
    @(negedge clk); #2;
    rst = 0; #1;
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_count", int'(count), 0);
    check("rst_done", int'(done), 0);
    check("rst_overflow", int'(overflow), 0);
    model_reset();
    enable = 0; clear = 0; in_valid = 0; rd_en = 0;
    @(negedge clk);
    rst = 1;
  endtask

  // Monitor: every readback word the DUT presents is matched against the oldest pending expectation
  always @(negedge clk) begin
    if (rd_valid) begin
      if (sb.size() == 0) begin
        check("rd_valid_unexpected", 1, 0);
      end else begin
        check("rd_data", int'(rd_data), sb.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int burst8 [8];
    int d, pv, addr;
    bit en, clr, v, rd;
    burst8 = '{32'h00000, 32'h01011, 32'h01021, 32'h02012, 32'h02022, 32'h03013, 32'h03023, 32'h00420};
    model_reset();
    for (int i = 0; i < DEPTH; i++) begin m_ram[i] = 0; m_written[i] = 0; end

    repeat (2) @(negedge clk);
    #1;
    check("init_rd_valid", int'(rd_valid), 0);
    check("init_count", int'(count), 0);
    check("init_done", int'(done), 0);
    check("init_overflow", int'(overflow), 0);
    rst = 1;

    // 8-flit burst ended by idle timeout
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 1, burst8[i], 0, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus(1, 0, 0, 0, 0, 0);
    check("burst8_not_done_yet", int'(done), 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    check("burst8_count", int'(count), EXP8);
    check("burst8_done", int'(done), 1);
    check("burst8_overflow", int'(overflow), 0);
    check("burst8_mem0", m_ram[0], (EXP8 == 8) ? 32'h00000 : 32'h01011);
    for (int i = 0; i < EXP8; i++) applyStimulus(1, 0, 0, 0, 1, i);
    applyStimulus(1, 0, 0, 0, 1, 31);
    applyStimulus(1, 0, 0, 0, 0, 0);

    // full 30-flit burst, then overflow flit, then clear colliding with a flit
    applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 1, $urandom_range(1, (1 << DW) - 1), 0, 0);
    check("full_count", int'(count), DEPTH);
    check("full_done", int'(done), 1);
    applyStimulus(1, 0, 1, 32'h5A5A5, 0, 0);
    check("full_overflow", int'(overflow), 1);
    applyStimulus(1, 0, 0, 0, 1, DEPTH - 1);
    applyStimulus(0, 1, 1, 32'h12345, 0, 0);
    check("clear_done", int'(done), 0);
    check("clear_overflow", int'(overflow), 0);
    check("clear_count", int'(count), 0);

    // reset mid-burst, then a fresh burst restarts at address 0
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1, 32'h00100 + i, 0, 0);
    pulseReset();
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 32'h0A000 + i, 0, 0);
    check("restart_count", int'(count), 3);
    applyStimulus(1, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 1, 2);

    // random traffic with varying flit density
    pv = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 40 == 0) pv = $urandom_range(0, 100);
      en   = ($urandom % 10) != 0;
      clr  = (($urandom % 150) == 0) || (m_finished && ($urandom % 12) == 0);
      v    = ($urandom % 100) < pv;
      d    = (($urandom % 8) == 0) ? 0 : $urandom_range(1, (1 << DW) - 1);
      addr = $urandom_range(0, 31);
      rd   = ($urandom % 3) == 0;
      if (addr < DEPTH && !m_written[addr]) rd = 0;
      applyStimulus(en, clr, v, d, rd, addr);
    end

    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
